prbs9_bert_ctrl: RTL and testbench
==================================

# prbs9_bert_ctrl

Bit-error-rate test controller for the PRBS9 generator (`prbs9_mod`). It drives the generator's `enable` for the duration of a test and self-synchronises a local PRBS9 reference to the looped-back bit stream. It then counts received bits and bit errors over a programmable window and reports the results. It sits between the control/register side (start, length, results) and the PRBS9 datapath plus the external loopback.

## Interface

Parameters:
- `CNT_W`, 32, width of the bit and error counters and of `n_bits`.
- `SYNC_LEN`, 32, consecutive correct predictions required to declare lock.
- `SYNC_TIMEOUT`, 4096, `rx_valid` bits allowed in SYNC before the test is declared failed.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-low.
- `start`  in  1  one-cycle request to begin a test; honoured only in IDLE.
- `abort`  in  1  terminate the test in progress; returns to IDLE.
- `n_bits`  in  CNT_W  number of bits to measure after lock; sampled on the accepted `start`.
- `rx_bit`  in  1  looped-back PRBS bit.
- `rx_valid`  in  1  qualifies `rx_bit`.
- `gen_enable`  out  1  drives `prbs9_mod` `enable`.
- `busy`  out  1  high in SYNC and MEASURE.
- `locked`  out  1  high in MEASURE.
- `done`  out  1  one-cycle pulse on test completion.
- `sync_fail`  out  1  last test timed out in SYNC; held until the next accepted `start`.
- `bit_cnt`  out  CNT_W  bits measured.
- `err_cnt`  out  CNT_W  errored bits; saturating.

## Operation

Polynomial and register:
- Polynomial x^9 + x^5 + 1, using a 9-bit register `s[8:0]`.
- New bit enters `s[0]`.
- Prediction is `p = s[8] ^ s[4]`.

FSM states are IDLE, SYNC, MEASURE and DONE.

- **IDLE**
  - All flag outputs are low.
  - On `start`: latch `n_bits`, clear `bit_cnt`, `err_cnt`, `sync_fail`, `s` and the sync counters, then go to SYNC.
- **SYNC**
  - `gen_enable=1`.
  - Each `rx_valid` shifts `rx_bit` into `s` and increments `fill` (saturates at 9) and `sync_bits`.
  - Once `fill==9`, each `rx_valid` compares `rx_bit` against `p`, evaluated before the shift:
    - match with `s!=0`: `match_cnt++`;
    - mismatch, or `s==0`: `match_cnt=0`. The all-zero register is a lock trap and never counts as a match.
  - `match_cnt==SYNC_LEN`: go to MEASURE.
  - Otherwise, `sync_bits==SYNC_TIMEOUT`: set `sync_fail`, go to DONE.
  - If both conditions occur in the same cycle, lock wins.
- **MEASURE**
  - `gen_enable=1`, `locked=1`.
  - The reference runs free: each `rx_valid` shifts `p` into `s`, not `rx_bit`, so a single channel error counts exactly once.
  - Each `rx_valid`: `bit_cnt++`. If `rx_bit!=p`, `err_cnt++`, saturating at all-ones.
  - When registered `bit_cnt==n_bits`, go to DONE. Further `rx_valid` bits are not counted.
  - If `n_bits==0`, DONE is reached on the cycle after entering MEASURE, with `bit_cnt=0`.
- **DONE**
  - `gen_enable=0`, `done=1` for exactly this one cycle.
  - Unconditionally go to IDLE.

Other rules:
- `abort` in SYNC or MEASURE: go to IDLE on the next edge. No `done` pulse; counters hold their current values.
- `abort` has priority over every other transition. In IDLE or DONE it has no effect.
- `start` outside IDLE is ignored.
- Results (`bit_cnt`, `err_cnt`, `sync_fail`) hold in IDLE until the next accepted `start`.

## Timing

- Reset values: state IDLE, all outputs 0, `s=0`, all counters 0. Reset mid-test returns to IDLE with all results cleared.
- All outputs are registered.
- `gen_enable` rises on the first edge after the `start` edge.
- Lock is declared at the earliest `9+SYNC_LEN` valid bits after the loopback stream starts. `locked` rises one cycle after the SYNC_LEN-th match.
- `done` is asserted on the first edge after the last counted bit. `bit_cnt` and `err_cnt` are final on the same cycle as `done`.
- Loopback latency is arbitrary; the sync logic does not depend on it.
- `rx_valid=0` freezes `s` and all counters.

## Structure

- Shared package `prbs_pkg` holds:
  - state enum `bert_state_t`;
  - `PRBS9_LEN=9`, `PRBS9_TAP_A=8`, `PRBS9_TAP_B=4`.
  - `prbs9_mod` should use the same constants.
- One sub-module, `prbs9_sync_checker`: owns `s`, `fill`, `match_cnt` and the mismatch output, with a `free_run` input that selects shifting `p` versus `rx_bit`.
- The FSM, counters and result registers live in the top level.

## Test plan

- Zero-delay loopback of `prbs9_mod`, `n_bits=1000` → `locked` after about 41 valid bits; `done` pulse; `bit_cnt=1000`, `err_cnt=0`, `sync_fail=0`.
- Same setup with one `rx_bit` inverted at measured bit 500 → `err_cnt=1`. Inverting bits 100, 101 and 600 → `err_cnt=3`.
- `rx_bit` stuck at 0 → no lock; `sync_fail=1` and `done` after 4096 valid bits; `bit_cnt=0`.
- Loopback delayed 37 cycles with `rx_valid` toggling every other cycle → lock achieved; `err_cnt=0` over `n_bits=200`.
- `abort` at measured bit 300 → IDLE next cycle, no `done`, `bit_cnt=300`. A `start` issued while busy has no effect.
- `rst` low during MEASURE → all outputs 0 the next cycle. A new `start` then runs a clean test.

Source files
------------

// File: rtl/prbs_pkg.sv
// Shared PRBS9 definitions: polynomial constants, BERT FSM state type, predictor helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package prbs_pkg;

  // x^9 + x^5 + 1 on a 9-bit register; new bit enters bit 0.
  localparam int PRBS9_LEN   = 9;
  localparam int PRBS9_TAP_A = 8;
  localparam int PRBS9_TAP_B = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } bert_state_t;

  // Next PRBS9 bit implied by the current register contents.
  function automatic logic prbs9_predict(input logic [PRBS9_LEN-1:0] s);
    return s[PRBS9_TAP_A] ^ s[PRBS9_TAP_B];
  endfunction

endpackage

// File: rtl/prbs9_sync_checker.sv
// PRBS9 reference register with fill/match tracking; flags lock and per-bit mismatch.
// Latency: mismatch is combinational on the current bit; lock_hit reflects registered match count.
// Backpressure: none; state advances only on shift_en, otherwise frozen.
module prbs9_sync_checker
  import prbs_pkg::*;
#(
  parameter int SYNC_LEN = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic shift_en,
  input  logic free_run,
  input  logic rx_bit,
  output logic mismatch,
  output logic lock_hit
);

  localparam int MATCH_W = $clog2(SYNC_LEN + 1);
  localparam int FILL_W  = $clog2(PRBS9_LEN + 1);

  logic [PRBS9_LEN-1:0] s;
  logic [FILL_W-1:0]    fill;
  logic [MATCH_W-1:0]   match_cnt;
  logic                 pred;
  logic                 filled;
  logic                 s_zero;

  assign pred     = prbs9_predict(s);
  assign filled   = (fill == FILL_W'(PRBS9_LEN));
  assign s_zero   = (s == '0);
  assign mismatch = rx_bit ^ pred;
  assign lock_hit = (match_cnt == MATCH_W'(SYNC_LEN));

  // Shift the reference and track consecutive correct predictions. In free-run
  // the register feeds itself so a channel error cannot corrupt the reference.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      s         <= '0;
      fill      <= '0;
      match_cnt <= '0;
    end else if (shift_en) begin
      s <= {s[PRBS9_LEN-2:0], (free_run ? pred : rx_bit)};
      if (!free_run) begin
        if (!filled) begin
          fill <= fill + 1'b1;
        end else if (!mismatch && !s_zero) begin
          // All-zero register predicts zeros forever; never let it build lock.
          if (!lock_hit) begin
            match_cnt <= match_cnt + 1'b1;
          end
        end else begin
          match_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/prbs9_bert_ctrl.sv
// PRBS9 BERT controller: enables the generator, syncs to loopback, counts bits/errors over a window.
// Latency: all outputs registered; done pulses one cycle after the last counted bit.
// Backpressure: none; rx_valid=0 freezes the reference and counters, abort returns to IDLE.
module prbs9_bert_ctrl
  import prbs_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int SYNC_LEN     = 32,
  parameter int SYNC_TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] n_bits,
  input  logic             rx_bit,
  input  logic             rx_valid,
  output logic             gen_enable,
  output logic             busy,
  output logic             locked,
  output logic             done,
  output logic             sync_fail,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int SB_W = $clog2(SYNC_TIMEOUT + 1);

  bert_state_t      state;
  logic [CNT_W-1:0] n_bits_q;
  logic [SB_W-1:0]  sync_bits;

  logic in_sync;
  logic in_meas;
  logic meas_open;
  logic clr_sync;
  logic shift_en;
  logic mismatch;
  logic lock_hit;
  logic timeout;

  assign in_sync   = (state == SYNC);
  assign in_meas   = (state == MEASURE);
  assign meas_open = (bit_cnt != n_bits_q);
  assign clr_sync  = (state == IDLE) && start;
  assign timeout   = (sync_bits == SB_W'(SYNC_TIMEOUT));
  // Once the window is full, later bits must not advance the reference or counters.
  assign shift_en  = rx_valid && !abort && (in_sync || (in_meas && meas_open));

  prbs9_sync_checker #(
    .SYNC_LEN (SYNC_LEN)
  ) u_sync (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr_sync),
    .shift_en (shift_en),
    .free_run (in_meas),
    .rx_bit   (rx_bit),
    .mismatch (mismatch),
    .lock_hit (lock_hit)
  );

  // Test sequencing, result counters and registered flag outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      n_bits_q   <= '0;
      sync_bits  <= '0;
      gen_enable <= 1'b0;
      busy       <= 1'b0;
      locked     <= 1'b0;
      done       <= 1'b0;
      sync_fail  <= 1'b0;
      bit_cnt    <= '0;
      err_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_bits_q   <= n_bits;
            sync_bits  <= '0;
            bit_cnt    <= '0;
            err_cnt    <= '0;
            sync_fail  <= 1'b0;
            gen_enable <= 1'b1;
            busy       <= 1'b1;
            state      <= SYNC;
          end
        end

        SYNC: begin
          if (abort) begin
            gen_enable <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            if (rx_valid && !timeout) begin
              sync_bits <= sync_bits + 1'b1;
            end
            // Lock takes precedence over a coincident timeout.
            if (lock_hit) begin
              locked <= 1'b1;
              state  <= MEASURE;
            end else if (timeout) begin
              sync_fail  <= 1'b1;
              gen_enable <= 1'b0;
              busy       <= 1'b0;
              done       <= 1'b1;
              state      <= DONE;
            end
          end
        end

        MEASURE: begin
          if (abort) begin
            gen_enable <= 1'b0;
            busy       <= 1'b0;
            locked     <= 1'b0;
            state      <= IDLE;
          end else if (!meas_open) begin
            gen_enable <= 1'b0;
            busy       <= 1'b0;
            locked     <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end else if (rx_valid) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (mismatch && (err_cnt != '1)) begin
              err_cnt <= err_cnt + 1'b1;
            end
          end
        end

        DONE: begin
          state <= IDLE;
        end

        default: begin
          gen_enable <= 1'b0;
          busy       <= 1'b0;
          locked     <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prbs9_bert_ctrl.sv
// Bench for prbs9_bert_ctrl: behavioural PRBS9 source with delay line, error injection, scoreboard.
// Latency: expected results are queued per test and compared on each done pulse.
// Backpressure: bench models rx_valid gaps (continuous, toggling, random).
module tb_prbs9_bert_ctrl;

  localparam int CNT_W        = 32;
  localparam int SYNC_LEN     = 32;
  localparam int SYNC_TIMEOUT = 4096;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] n_bits;
  logic             rx_bit;
  logic             rx_valid;
  logic             gen_enable;
  logic             busy;
  logic             locked;
  logic             done;
  logic             sync_fail;
  logic [CNT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] err_cnt;

  always #5 clk = ~clk;

  prbs9_bert_ctrl #(
    .CNT_W        (CNT_W),
    .SYNC_LEN     (SYNC_LEN),
    .SYNC_TIMEOUT (SYNC_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .n_bits     (n_bits),
    .rx_bit     (rx_bit),
    .rx_valid   (rx_valid),
    .gen_enable (gen_enable),
    .busy       (busy),
    .locked     (locked),
    .done       (done),
    .sync_fail  (sync_fail),
    .bit_cnt    (bit_cnt),
    .err_cnt    (err_cnt)
  );

  typedef struct packed {
    logic [31:0] bits;
    logic [31:0] errs;
    logic        fail;
  } exp_t;

  typedef struct packed {
    logic v;
    logic b;
  } lb_t;

  exp_t sb[$];
  lb_t  line[$];

  int vectors     = 0;
  int miscompares = 0;

  // Source / channel model state
  logic [8:0] g;
  int         cyc_n;
  int         delay_d;
  int         vmode;
  bit         stuck;
  int         m;
  int         pre;
  bit         ev_done;
  bit         err_flag [0:2047];
  int         abort_at;
  int         rst_at;
  int         start_mid_at;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // One clock: observe after the edge, then drive the next inputs.
  task automatic tick();
    lb_t tx;
    lb_t rx;
    logic ob;
    bit strobe;
    @(posedge clk);
    #1;
    cyc_n++;
    if (done) ev_done = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    rst   = 1'b1;
    if (vmode == 0)      strobe = 1'b1;
    else if (vmode == 1) strobe = ((cyc_n % 2) == 0);
    else                 strobe = ($urandom_range(0, 9) < 7);
    tx = '0;
    if (gen_enable && strobe) begin
      ob   = g[8] ^ g[4];
      g    = {g[7:0], ob};
      tx.v = 1'b1;
      tx.b = ob;
    end
    line.push_back(tx);
    if (line.size() > delay_d) rx = line.pop_front();
    else                       rx = '0;
    if (stuck) rx.b = 1'b0;
    if (locked && abort_at >= 0 && m == abort_at) begin
      abort    = 1'b1;
      abort_at = -1;
    end
    if (locked && rst_at >= 0 && m == rst_at) begin
      rst    = 1'b0;
      rst_at = -1;
    end
    if (locked && start_mid_at >= 0 && m == start_mid_at) begin
      start        = 1'b1;
      n_bits       = 5;
      start_mid_at = -1;
    end
    if (rx.v) begin
      if (busy && !locked) pre++;
      if (locked) begin
        if (m < 2048 && err_flag[m]) rx.b = ~rx.b;
        m++;
      end
    end
    rx_valid = rx.v;
    rx_bit   = rx.b;
  endtask

  task automatic clear_errs();
    for (int i = 0; i < 2048; i++) err_flag[i] = 1'b0;
  endtask

  task automatic launch(input int n);
    line.delete();
    m       = 0;
    pre     = 0;
    ev_done = 1'b0;
    g       = 9'($urandom_range(1, 511));
    tick();
    start  = 1'b1;
    n_bits = n;
    tick();
    check("gen_enable_rise", {31'd0, gen_enable}, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) tick();
  endtask

  // Full test: expected result derived from window size and injected errors.
  task automatic run(input int n, input int d, input int vm, input bit stk, input bit chk_lock);
    exp_t e;
    int   ne;
    int   k;
    ne = 0;
    delay_d = d;
    vmode   = vm;
    stuck   = stk;
    for (int i = 0; i < n && i < 2048; i++) if (err_flag[i]) ne++;
    e.bits = stk ? 32'd0 : 32'(n);
    e.errs = stk ? 32'd0 : 32'(ne);
    e.fail = stk;
    sb.push_back(e);
    launch(n);
    k = 0;
    while (!ev_done && k < 12000) begin
      tick();
      k++;
    end
    check("run_done", {31'd0, ev_done}, 1);
    if (chk_lock) check("lock_bits", pre, 9 + SYNC_LEN + 1);
    if (stk) begin
      vectors++;
      if (pre < SYNC_TIMEOUT || pre > SYNC_TIMEOUT + 1) begin
        miscompares++;
        $display("FAIL timeout_bits: got %0d, expected %0d..%0d", pre, SYNC_TIMEOUT, SYNC_TIMEOUT + 1);
      end
    end
    clear_errs();
    stuck = 1'b0;
    drain();
  endtask

  // Scoreboard monitor: every done pulse pops one expected result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (done) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_done: got done=1, expected none");
        end else begin
          e = sb.pop_front();
          check("bit_cnt", bit_cnt, e.bits);
          check("err_cnt", err_cnt, e.errs);
          check("sync_fail", {31'd0, sync_fail}, {31'd0, e.fail});
        end
      end
    end
  end

  initial begin
    int n;
    int k;
    rst = 1'b0; start = 1'b0; abort = 1'b0; n_bits = '0;
    rx_bit = 1'b0; rx_valid = 1'b0;
    cyc_n = 0; delay_d = 0; vmode = 0; stuck = 1'b0;
    m = 0; pre = 0; ev_done = 1'b0;
    abort_at = -1; rst_at = -1; start_mid_at = -1;
    g = 9'h1;
    clear_errs();

    repeat (3) @(posedge clk);
    #1;
    check("rst_gen_enable", {31'd0, gen_enable}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_locked", {31'd0, locked}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_sync_fail", {31'd0, sync_fail}, 0);
    check("rst_bit_cnt", bit_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
    rst = 1'b1;
    drain();

    // Clean zero-delay loopback, with an ignored start while measuring.
    start_mid_at = 50;
    run(1000, 0, 0, 1'b0, 1'b1);

    // Single and multiple injected errors.
    err_flag[500] = 1'b1;
    run(1000, 0, 0, 1'b0, 1'b1);
    err_flag[100] = 1'b1; err_flag[101] = 1'b1; err_flag[600] = 1'b1;
    run(1000, 0, 0, 1'b0, 1'b1);

    // Empty window.
    run(0, 0, 0, 1'b0, 1'b1);

    // Stuck-at-zero input never locks.
    run(100, 0, 0, 1'b1, 1'b0);

    // Long loopback latency with every-other-cycle valid.
    run(200, 37, 1, 1'b0, 1'b0);

    // Randomized windows, latencies, valid patterns and error positions.
    for (int r = 0; r < 6; r++) begin
      int d;
      int vm;
      int ne;
      n  = $urandom_range(1, 700);
      d  = $urandom_range(0, 40);
      vm = $urandom_range(0, 2);
      ne = $urandom_range(0, 4);
      for (int i = 0; i < ne; i++) err_flag[$urandom_range(0, n + 3)] = 1'b1;
      run(n, d, vm, 1'b0, vm == 0);
    end

    // Abort mid-measurement: no done, counters hold.
    delay_d = 0; vmode = 0;
    abort_at = 300;
    launch(1000);
    k = 0;
    while (abort_at >= 0 && k < 5000) begin tick(); k++; end
    tick();
    check("abort_busy", {31'd0, busy}, 0);
    check("abort_locked", {31'd0, locked}, 0);
    check("abort_gen_enable", {31'd0, gen_enable}, 0);
    check("abort_bit_cnt", bit_cnt, 300);
    check("abort_err_cnt", err_cnt, 0);
    drain();
    check("abort_no_done", {31'd0, ev_done}, 0);
    check("abort_hold_bit_cnt", bit_cnt, 300);

    // Reset during measurement clears everything, then a clean test.
    rst_at = 100;
    launch(1000);
    k = 0;
    while (rst_at >= 0 && k < 5000) begin tick(); k++; end
    tick();
    check("mrst_gen_enable", {31'd0, gen_enable}, 0);
    check("mrst_busy", {31'd0, busy}, 0);
    check("mrst_locked", {31'd0, locked}, 0);
    check("mrst_done", {31'd0, done}, 0);
    check("mrst_sync_fail", {31'd0, sync_fail}, 0);
    check("mrst_bit_cnt", bit_cnt, 0);
    check("mrst_err_cnt", err_cnt, 0);
    drain();
    err_flag[7] = 1'b1;
    run(300, 0, 0, 1'b0, 1'b1);

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
